cpu_sequencer: RTL and testbench
================================

# cpu_sequencer

Multi-cycle instruction sequencer for the single-issue CPU datapath. It fetches a 32-bit instruction over an instruction-memory handshake, holds it in an instruction register, and steps the datapath through decode, execute, memory and write-back. It drives the register-file and data-memory strobes, ALU operation and mux selects. It replaces free-running combinational control with a clocked FSM that tolerates variable-latency memories.

## Interface
- PC_W, 8, program-counter / instruction-address width
- CNT_W, 16, retired-instruction counter width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- run  in  1  level enable; sampled at IDLE and at instruction retire
- imem_req  out  1  instruction fetch request
- imem_addr  out  PC_W  fetch address (= pc)
- imem_ack  in  1  fetch complete; imem_data valid this cycle
- imem_data  in  32  instruction word
- dmem_req  out  1  data-memory request (load/store)
- dmem_we  out  1  1 = store, 0 = load; meaningful only with dmem_req
- dmem_ack  in  1  data access complete
- alu_op  out  4  IR[18:15]
- src_sel  out  1  IR[31]; 1 = immediate operand, 0 = RT
- wb_sel  out  1  0 when op = LOAD (data memory), else 1 (ALU)
- rf_we  out  1  register-file write strobe, one cycle
- rs / rd / rt  out  6 each  IR[30:25] / IR[24:19] / IR[14:9]
- imm  out  9  IR[8:0]
- busy  out  1  state != IDLE
- instr_count  out  CNT_W  retired instructions, saturating

## Operation
- Opcodes: LOAD 4'b0100, STORE 4'b0110, NOP 4'b1111; every other value is an ALU op.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB.
- IDLE -> FETCH when run = 1; otherwise stay.
- FETCH: imem_req = 1 until the cycle imem_ack = 1; that edge loads IR <= imem_data -> DECODE.
- DECODE: one cycle -> EXEC.
- EXEC: one cycle. LOAD/STORE -> MEM; NOP -> retire; else -> WB.
- MEM: dmem_req = 1, dmem_we = (op == STORE), held until dmem_ack. On ack, LOAD -> WB, STORE -> retire.
- WB: rf_we = 1 for exactly this cycle -> retire.
- Retire (on the exiting edge): pc <= pc + 1, wrapping 2^PC_W-1 -> 0. instr_count <= instr_count + 1, saturating at all-ones. Next state FETCH if run = 1, else IDLE.
- run = 0 mid-instruction does not abort; the instruction completes, then IDLE.
- imem_ack outside FETCH and dmem_ack outside MEM are ignored.
- rf_we, dmem_req and imem_req are never asserted in the same cycle.
- Field outputs, alu_op, src_sel and wb_sel decode from IR continuously (Moore). Strobes decode from state only.

## Timing
- Reset (async assert, sync release by system): state IDLE, pc 0, IR 0, instr_count 0; all strobes 0, so fields, alu_op, src_sel and wb_sel follow IR = 0 (wb_sel = 1).
- Zero-wait memories (ack in first request cycle): ALU op 4 cycles, LOAD 5, STORE 4, NOP 3, measured from FETCH entry to next FETCH entry.
- Each memory wait cycle adds one cycle; the request stays high and the address stays stable throughout.
- First imem_req rises the cycle after run is sampled high in IDLE.

## Structure
- cpu_pkg: opcode localparams (OP_LOAD, OP_STORE, OP_NOP), IR field bit positions, enum seq_state_t.
- One sub-module, instr_fields: combinational split of the 32-bit IR into ri/rs/rd/op/rt/imm. It is reusable by the datapath.
- The sequencer itself is a single FSM plus pc, IR and counter registers.

## Test plan
- Reset with run = 0 -> busy = 0, imem_req = 0, pc = 0, instr_count = 0 for 10 cycles. Mid-FETCH rst_n pulse -> outputs return to reset values immediately.
- run = 1, zero-wait imem, ALU word 32'h8209_0005 -> imem_req 1 cycle, rf_we pulses in cycle 4, src_sel = 1, imm = 5, pc = 1, instr_count = 1.
- LOAD with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles with dmem_we = 0, wb_sel = 0, then 1-cycle rf_we. STORE -> dmem_we = 1, rf_we never asserted.
- NOP -> no rf_we and no dmem_req; retires in 3 cycles; pc increments.
- pc preset to 8'hFF via 255 NOPs -> next retire gives pc = 0. Count forced near max -> saturates at 16'hFFFF.
- Drop run during MEM of a LOAD -> WB completes, state IDLE, busy = 0, no further imem_req. Stray acks in IDLE cause no state change.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU sequencer and datapath:
// opcode values, instruction-word field layout and the sequencer state type.
package cpu_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned REG_W   = 6;
    localparam int unsigned IMM_W   = 9;

    // Instruction field bit positions (LSB of each field)
    localparam int unsigned RI_BIT  = 31;
    localparam int unsigned RS_LSB  = 25;
    localparam int unsigned RD_LSB  = 19;
    localparam int unsigned OP_LSB  = 15;
    localparam int unsigned RT_LSB  = 9;
    localparam int unsigned IMM_LSB = 0;

    localparam logic [OP_W-1:0] OP_LOAD  = 4'b0100;
    localparam logic [OP_W-1:0] OP_STORE = 4'b0110;
    localparam logic [OP_W-1:0] OP_NOP   = 4'b1111;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } seq_state_t;

endpackage

// File: rtl/instr_fields.sv
// Combinational split of a 32-bit instruction word into its fields.
// Ports: ir_i (instruction word) -> ri_o (immediate select), rs_o, rd_o,
//        op_o, rt_o, imm_o.
module instr_fields
    import cpu_pkg::*;
(
    input  logic [INSTR_W-1:0] ir_i,
    output logic               ri_o,
    output logic [REG_W-1:0]   rs_o,
    output logic [REG_W-1:0]   rd_o,
    output logic [OP_W-1:0]    op_o,
    output logic [REG_W-1:0]   rt_o,
    output logic [IMM_W-1:0]   imm_o
);

    assign ri_o  = ir_i[RI_BIT];
    assign rs_o  = ir_i[RS_LSB  +: REG_W];
    assign rd_o  = ir_i[RD_LSB  +: REG_W];
    assign op_o  = ir_i[OP_LSB  +: OP_W];
    assign rt_o  = ir_i[RT_LSB  +: REG_W];
    assign imm_o = ir_i[IMM_LSB +: IMM_W];

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: fetch over an imem handshake, then
// decode / execute / memory / write-back, tolerating variable-latency memories.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   run                         level enable, sampled in IDLE and at retire
//   imem_req/addr/ack/data      instruction fetch handshake
//   dmem_req/we/ack             data-memory handshake
//   alu_op, src_sel, wb_sel     datapath controls decoded from IR
//   rf_we                       one-cycle register-file write strobe
//   rs, rd, rt, imm             IR fields
//   busy                        sequencer not idle
//   instr_count                 saturating retired-instruction counter
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned PC_W  = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    output logic               dmem_req,
    output logic               dmem_we,
    input  logic               dmem_ack,
    output logic [OP_W-1:0]    alu_op,
    output logic               src_sel,
    output logic               wb_sel,
    output logic               rf_we,
    output logic [REG_W-1:0]   rs,
    output logic [REG_W-1:0]   rd,
    output logic [REG_W-1:0]   rt,
    output logic [IMM_W-1:0]   imm,
    output logic               busy,
    output logic [CNT_W-1:0]   instr_count
);

    seq_state_t         state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Strobes are flops loaded from the next state, so they are a pure
    // function of the current state with no combinational path from inputs.
    logic imem_req_q, imem_req_d;
    logic dmem_req_q, dmem_req_d;
    logic dmem_we_q,  dmem_we_d;
    logic rf_we_q,    rf_we_d;
    logic busy_q,     busy_d;

    logic            retire;
    logic            ri;
    logic [OP_W-1:0] op;

    // Field split of the held instruction
    instr_fields u_fields (
        .ir_i  (ir_q),
        .ri_o  (ri),
        .rs_o  (rs),
        .rd_o  (rd),
        .op_o  (op),
        .rt_o  (rt),
        .imm_o (imm)
    );

    // Next-state, retire bookkeeping and next strobe values
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        retire  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_data;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (op == OP_LOAD || op == OP_STORE) state_d = S_MEM;
                else if (op == OP_NOP)               retire  = 1'b1;
                else                                 state_d = S_WB;
            end
            S_MEM: begin
                if (dmem_ack) begin
                    if (op == OP_LOAD) state_d = S_WB;
                    else               retire  = 1'b1;
                end
            end
            S_WB:    retire  = 1'b1;
            default: state_d = S_IDLE;
        endcase

        // Retire: advance pc (wraps naturally), bump saturating count, and
        // re-sample run to decide between the next fetch and idle.
        if (retire) begin
            pc_d = pc_q + PC_W'(1);
            if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
            state_d = run ? S_FETCH : S_IDLE;
        end

        imem_req_d = (state_d == S_FETCH);
        dmem_req_d = (state_d == S_MEM);
        // IR cannot change between EXEC and MEM, so ir_q's opcode is valid here
        dmem_we_d  = (state_d == S_MEM) && (op == OP_STORE);
        rf_we_d    = (state_d == S_WB);
        busy_d     = (state_d != S_IDLE);
    end

    // State, architectural registers and registered strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            ir_q       <= '0;
            cnt_q      <= '0;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            rf_we_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            cnt_q      <= cnt_d;
            imem_req_q <= imem_req_d;
            dmem_req_q <= dmem_req_d;
            dmem_we_q  <= dmem_we_d;
            rf_we_q    <= rf_we_d;
            busy_q     <= busy_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign dmem_req    = dmem_req_q;
    assign dmem_we     = dmem_we_q;
    assign rf_we       = rf_we_q;
    assign busy        = busy_q;
    assign imem_addr   = pc_q;
    assign instr_count = cnt_q;
    assign alu_op      = op;
    assign src_sel     = ri;
    assign wb_sel      = (op != OP_LOAD);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: lock-step random instruction stream
// with random memory latencies and run toggling, checked every cycle against
// a per-instruction phase model (fetch waits, decode, exec, mem waits, wb).
module tb_cpu_sequencer;

    localparam int unsigned PC_W  = 8;
    localparam int unsigned CNT_W = 10;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;
    localparam int          PC_MOD  = 1 << PC_W;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             run = 1'b0;
    logic             imem_ack = 1'b0;
    logic [31:0]      imem_data = 32'h0;
    logic             dmem_ack = 1'b0;
    logic             imem_req, dmem_req, dmem_we, rf_we, busy, src_sel, wb_sel;
    logic [PC_W-1:0]  imem_addr;
    logic [3:0]       alu_op;
    logic [5:0]       rs, rd, rt;
    logic [8:0]       imm;
    logic [CNT_W-1:0] instr_count;

    cpu_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_ack    (dmem_ack),
        .alu_op      (alu_op),
        .src_sel     (src_sel),
        .wb_sel      (wb_sel),
        .rf_we       (rf_we),
        .rs          (rs),
        .rd          (rd),
        .rt          (rt),
        .imm         (imm),
        .busy        (busy),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    int          pc_m = 0;
    int          cnt_m = 0;
    logic [31:0] ir_m = 32'h0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int fld(input logic [31:0] w, input int lsb, input int width);
        return int'((w >> lsb) & ((32'd1 << width) - 32'd1));
    endfunction

    // Expected strobes for the phase, plus pc, count and IR-derived fields
    task automatic check_cycle(input bit ei, input bit ed, input bit er, input bit eb,
                               input string ph);
        chk({ph, ":imem_req"},  32'(imem_req),    32'(ei));
        chk({ph, ":dmem_req"},  32'(dmem_req),    32'(ed));
        chk({ph, ":rf_we"},     32'(rf_we),       32'(er));
        chk({ph, ":busy"},      32'(busy),        32'(eb));
        chk({ph, ":pc"},        32'(imem_addr),   32'(pc_m));
        chk({ph, ":count"},     32'(instr_count), 32'(cnt_m));
        chk({ph, ":alu_op"},    32'(alu_op),      32'(fld(ir_m, 15, 4)));
        chk({ph, ":src_sel"},   32'(src_sel),     32'(fld(ir_m, 31, 1)));
        chk({ph, ":wb_sel"},    32'(wb_sel),      32'(fld(ir_m, 15, 4) != 4));
        chk({ph, ":rs"},        32'(rs),          32'(fld(ir_m, 25, 6)));
        chk({ph, ":rd"},        32'(rd),          32'(fld(ir_m, 19, 6)));
        chk({ph, ":rt"},        32'(rt),          32'(fld(ir_m, 9, 6)));
        chk({ph, ":imm"},       32'(imm),         32'(fld(ir_m, 0, 9)));
    endtask

    task automatic stray();
        imem_ack = 1'($urandom_range(0, 1));
        dmem_ack = 1'($urandom_range(0, 1));
        run      = 1'($urandom_range(0, 1));
    endtask

    // Entered with the DUT in FETCH; leaves it in FETCH (run_end=1) or IDLE.
    task automatic exec_instr(input logic [31:0] w, input int wi, input int wd,
                              input bit run_end);
        int  op;
        bit  is_mem, has_wb;
        op     = fld(w, 15, 4);
        is_mem = (op == 4) || (op == 6);
        has_wb = (op != 6) && (op != 15);
        for (int k = 0; k <= wi; k++) begin
            check_cycle(1'b1, 1'b0, 1'b0, 1'b1, "fetch");
            imem_ack  = (k == wi);
            imem_data = (k == wi) ? w : $urandom;
            dmem_ack  = 1'($urandom_range(0, 1));
            run       = 1'($urandom_range(0, 1));
            step();
        end
        ir_m = w;
        check_cycle(1'b0, 1'b0, 1'b0, 1'b1, "decode");
        stray();
        step();
        check_cycle(1'b0, 1'b0, 1'b0, 1'b1, "exec");
        stray();
        if (!is_mem && !has_wb) run = run_end;
        step();
        if (is_mem) begin
            for (int k = 0; k <= wd; k++) begin
                check_cycle(1'b0, 1'b1, 1'b0, 1'b1, "mem");
                chk("mem:dmem_we", 32'(dmem_we), 32'(op == 6));
                dmem_ack = (k == wd);
                imem_ack = 1'($urandom_range(0, 1));
                run      = (k == wd && !has_wb) ? run_end : 1'($urandom_range(0, 1));
                step();
            end
        end
        if (has_wb) begin
            check_cycle(1'b0, 1'b0, 1'b1, 1'b1, "wb");
            stray();
            run = run_end;
            step();
        end
        pc_m = (pc_m + 1) % PC_MOD;
        if (cnt_m < CNT_MAX) cnt_m++;
    endtask

    // Entered in IDLE; n idle cycles with stray acks, then run=1 into FETCH.
    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            check_cycle(1'b0, 1'b0, 1'b0, 1'b0, "idle");
            imem_ack = 1'($urandom_range(0, 1));
            dmem_ack = 1'($urandom_range(0, 1));
            run      = 1'b0;
            step();
        end
        check_cycle(1'b0, 1'b0, 1'b0, 1'b0, "idle_go");
        imem_ack = 1'($urandom_range(0, 1));
        dmem_ack = 1'($urandom_range(0, 1));
        run      = 1'b1;
        step();
    endtask

    function automatic logic [31:0] mk_instr(input int kind);
        logic [31:0] w;
        w = $urandom;
        case (kind)
            0:       w[18:15] = 4'b0100;
            1:       w[18:15] = 4'b0110;
            2:       w[18:15] = 4'b1111;
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        bit re;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_cycles(10);

        // Directed: ALU, slow LOAD, STORE, NOP
        exec_instr(32'h8209_0005, 0, 0, 1'b1);
        chk("alu:imm", 32'(imm), 32'd5);
        chk("alu:src_sel", 32'(src_sel), 32'd1);
        chk("alu:pc", 32'(imem_addr), 32'd1);
        chk("alu:count", 32'(instr_count), 32'd1);
        exec_instr(mk_instr(0), 0, 3, 1'b1);
        exec_instr(mk_instr(1), 1, 2, 1'b1);
        exec_instr(mk_instr(2), 0, 0, 1'b1);
        chk("nop:pc", 32'(imem_addr), 32'd4);

        // Asynchronous reset in the middle of a fetch
        check_cycle(1'b1, 1'b0, 1'b0, 1'b1, "prerst");
        rst_n = 1'b0;
        #1;
        pc_m = 0;
        cnt_m = 0;
        ir_m = 32'h0;
        check_cycle(1'b0, 1'b0, 1'b0, 1'b0, "rst");
        @(negedge clk);
        rst_n = 1'b1;
        run = 1'b0;
        step();
        idle_cycles(3);

        // 256 NOPs walk pc through 8'hFF back to 0
        for (int i = 0; i < 256; i++) exec_instr(mk_instr(2), $urandom_range(0, 1), 0, 1'b1);
        chk("pc_wrap", 32'(imem_addr), 32'd0);

        // run dropped during a LOAD's memory wait: completes, then idles
        exec_instr(mk_instr(0), 1, 2, 1'b0);
        chk("drop:busy", 32'(busy), 32'd0);
        idle_cycles(5);

        // Random stream; long enough to saturate the counter
        for (int i = 0; i < 900; i++) begin
            re = ($urandom_range(0, 7) != 0);
            exec_instr(mk_instr(int'($urandom_range(0, 4))), $urandom_range(0, 3),
                       $urandom_range(0, 3), re);
            if (!re) idle_cycles($urandom_range(0, 3));
        end
        chk("cnt_sat", 32'(instr_count), 32'(CNT_MAX));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
